// File: rtl/timer_counter.sv
// Memory-mapped down-counter: CTRL/PRESET/COUNT registers driven by an IDLE/LOAD/CNT/EXPIRE FSM.
// Define TIMER_IRQ_EN to build the expiry flag, the CTRL.IM bit and the irq output.
module timer_counter #(
  parameter logic [31:0] PRESET_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StExpire} state_e;

`ifdef TIMER_IRQ_EN
  localparam logic [3:0] CtrlMask = 4'hf;
`else
  localparam logic [3:0] CtrlMask = 4'h7;
`endif

  state_e      state;
  logic [3:0]  ctrl;
  logic [3:0]  ctrl_d;
  logic [31:0] preset;
  logic [31:0] count;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_reload;

  assign ctrl_wr     = we && (addr == 2'd0);
  assign preset_wr   = we && (addr == 2'd1);
  assign auto_reload = (ctrl[2:1] == 2'b01);

  // A CTRL write always wins over the one-shot EN clear in EXPIRE.
  always_comb begin
    ctrl_d = ctrl;
    if (ctrl_wr) begin
      ctrl_d = wdata[3:0] & CtrlMask;
    end else if (state == StExpire && !auto_reload) begin
      ctrl_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= StIdle;
      ctrl   <= 4'h0;
      preset <= PRESET_INIT;
      count  <= 32'h0;
    end else begin
      ctrl <= ctrl_d;
      if (preset_wr) begin
        preset <= wdata;
      end
      case (state)
        StIdle: begin
          if (ctrl[0]) state <= StLoad;
        end
        StLoad: begin
          count <= preset;
          state <= StCnt;
        end
        StCnt: begin
          if (!ctrl[0]) begin
            state <= StIdle;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // PRESET==0 lands here too, so COUNT never wraps.
            count <= 32'h0;
            state <= StExpire;
          end
        end
        StExpire: begin
          state <= auto_reload ? StLoad : StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    case (addr)
      2'd0:    rdata = {28'h0, ctrl};
      2'd1:    rdata = preset;
      2'd2:    rdata = count;
      default: rdata = 32'h0;
    endcase
  end

`ifdef TIMER_IRQ_EN
  logic flag;
  logic flag_d;
  logic expiring;

  assign expiring = (state == StCnt) && ctrl[0] && (count <= 32'd1);

  // One-shot flag is sticky until a CTRL write; auto-reload flag lasts only the EXPIRE cycle.
  always_comb begin
    flag_d = flag;
    if (expiring) begin
      flag_d = 1'b1;
    end else if (ctrl_wr) begin
      flag_d = 1'b0;
    end else if (state == StExpire && auto_reload) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag <= 1'b0;
      irq  <= 1'b0;
    end else begin
      flag <= flag_d;
      irq  <= flag_d & ctrl_d[3];
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL provide parameter PRESET_INIT, default 32'h0000_0000, value of PRESET after reset.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port addr  input  2  word select (byte address bits [3:2]) from the M-stage data address: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
REQ-005 SHALL have port we  input  1  write strobe, sampled on the rising edge of clk.
REQ-006 SHALL have port wdata  input  32  M-stage store data (already forwarded).
REQ-007 SHALL have port rdata  output  32  combinational read data for addr.
REQ-008 SHALL have port irq  output  1  registered interrupt request.

Function
REQ-009 SHALL hold CTRL[3:0]: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x same as 00), bit3 IM (interrupt mask, 1 = enabled); CTRL[31:4] SHALL read as 0.
REQ-010 SHALL update CTRL <= wdata[3:0] when we && addr==0, and PRESET <= wdata when we && addr==1; writes to addr 2 and 3 SHALL be ignored.
REQ-011 SHALL drive rdata = {28'b0,CTRL} / PRESET / COUNT / 32'h0 for addr 0/1/2/3, with no cycle of latency.
REQ-012 SHALL implement FSM states IDLE, LOAD, CNT, and EXPIRE.
REQ-013 In IDLE, when EN==1, the FSM SHALL go to LOAD on the next edge.
REQ-014 LOAD SHALL set COUNT <= PRESET and go to CNT.
REQ-015 In CNT, when EN==0, the FSM SHALL go to IDLE and COUNT SHALL hold.
REQ-016 In CNT, when EN==1 and COUNT>1, COUNT SHALL decrement by 1.
REQ-017 In CNT, when EN==1 and COUNT<=1, the FSM SHALL set COUNT <= 0 and go to EXPIRE.
REQ-018 In EXPIRE with MODE==01, the FSM SHALL go to LOAD, which reloads PRESET.
REQ-019 In EXPIRE with any other MODE, the FSM SHALL clear EN and go to IDLE.
REQ-020 On entry to EXPIRE, an internal flag SHALL be set; irq SHALL equal flag && IM.
REQ-021 In mode 00, the flag SHALL stay set until any CTRL write.
REQ-022 In mode 01, the flag SHALL be set for exactly one cycle (the EXPIRE cycle).
REQ-023 PRESET==0 SHALL behave as PRESET==1: CNT then EXPIRE after one cycle.
REQ-024 A PRESET write during CNT SHALL NOT alter the running COUNT; it SHALL take effect at the next LOAD.
REQ-025 If a CTRL write coincides with EXPIRE, the written CTRL value SHALL win, including EN, and the flag SHALL clear.
REQ-026 If a CTRL write sets EN=0 while in LOAD, the FSM SHALL complete the load and then go to IDLE from CNT on the next edge.
REQ-027 COUNT SHALL never wrap below 0.

Reset
REQ-028 On reset, the block SHALL asynchronously set CTRL=0, PRESET=PRESET_INIT, COUNT=0, state=IDLE, flag=0, and irq=0.
REQ-029 Reset asserted mid-count SHALL abort immediately, and no irq SHALL be produced after release until the block is re-enabled.

Configuration
REQ-030 With macro TIMER_IRQ_EN defined, the block SHALL generate irq as specified in REQ-020 to REQ-022.
REQ-031 With TIMER_IRQ_EN undefined, irq SHALL be constant 0, CTRL bit3 SHALL be unimplemented (reads 0, writes ignored), and the flag logic SHALL be absent; counting behaviour SHALL be unchanged.

Verification
REQ-032 Bench SHALL cover: reset, read addr 0/1/2 -> 0, PRESET_INIT, 0; irq=0.
REQ-033 Bench SHALL cover: PRESET=5, CTRL=4'b1001 -> COUNT goes 5,4,3,2,1 then 0; irq rises 7 cycles after the CTRL write edge and stays high; EN reads 0.
REQ-034 Bench SHALL cover: with irq high, write CTRL=4'b0000 -> irq low on the next edge.
REQ-035 Bench SHALL cover: PRESET=3, CTRL=4'b1011 -> irq one-cycle pulses every 5 cycles; COUNT reloads to 3 each period.
REQ-036 Bench SHALL cover: mid-count (COUNT=10) write PRESET=2 -> count continues 9,8,...; the next reload loads 2.
REQ-037 Bench SHALL cover: reset pulse at COUNT=7 -> all outputs 0 asynchronously; with TIMER_IRQ_EN undefined, scenario REQ-033 gives irq=0 and CTRL reads 4'b0000 after expiry.
